// File: rtl/dsp_mac_acc.sv
// dsp_mac_acc: sums a packet of signed products, rounds/shifts/saturates the sum to sample width,
// and presents one result per packet over a valid/ready handshake.
module dsp_mac_acc #(
   parameter int IN_WIDTH   = 35,
   parameter int ACC_WIDTH  = 48,
   parameter int FRAC_SHIFT = 16,
   parameter int OUT_WIDTH  = 17,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_valid,
   input  logic [IN_WIDTH-1:0]  i_data,
   input  logic                 i_last,
   output logic                 o_ready,
   output logic                 o_valid,
   output logic [OUT_WIDTH-1:0] o_data,
   output logic                 o_sat,
   output logic                 o_acc_ovf,
   output logic [CNT_WIDTH-1:0] o_beats,
   input  logic                 i_ready
);
   typedef enum logic {ACCUM, HOLD} state_t;
   localparam logic signed [ACC_WIDTH:0]   ONE   = 1;
   localparam logic signed [ACC_WIDTH:0]   HALF  = (ONE <<< FRAC_SHIFT) >>> 1;
   localparam logic signed [ACC_WIDTH:0]   O_MAX = (ONE <<< (OUT_WIDTH - 1)) - ONE;
   localparam logic signed [ACC_WIDTH:0]   O_MIN = -(ONE <<< (OUT_WIDTH - 1));
   localparam logic signed [ACC_WIDTH-1:0] A_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] A_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   state_t state, state_nxt;
   logic signed [ACC_WIDTH-1:0] acc, ext, sum;
   logic signed [ACC_WIDTH:0]   sum_wide, rnd;
   logic [CNT_WIDTH-1:0]        cnt, cnt_inc;
   logic [OUT_WIDTH-1:0]        out_q;
   logic                        ovf, add_ovf, take, out_sat;
   always_comb begin
      ext       = ACC_WIDTH'($signed(i_data));
      sum_wide  = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
      add_ovf   = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
      sum       = add_ovf ? (sum_wide[ACC_WIDTH] ? A_MIN : A_MAX) : sum_wide[ACC_WIDTH-1:0];
      // one guard bit keeps the half-LSB rounding add from wrapping at the clamp limits
      rnd       = ($signed({sum[ACC_WIDTH-1], sum}) + HALF) >>> FRAC_SHIFT;
      out_sat   = (rnd > O_MAX) || (rnd < O_MIN);
      out_q     = rnd > O_MAX ? O_MAX[OUT_WIDTH-1:0] : rnd < O_MIN ? O_MIN[OUT_WIDTH-1:0] : rnd[OUT_WIDTH-1:0];
      cnt_inc   = &cnt ? cnt : cnt + CNT_WIDTH'(1);
      o_valid   = state == HOLD;
      o_ready   = !o_valid || i_ready;
      take      = i_valid && o_ready;
      state_nxt = (take && i_last) ? HOLD : i_ready ? ACCUM : state;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         o_data    <= '0;
         o_sat     <= 1'b0;
         o_acc_ovf <= 1'b0;
         o_beats   <= '0;
      end else begin
         state <= state_nxt;
         if (take && i_last) begin
            o_data    <= out_q;
            o_sat     <= out_sat;
            o_acc_ovf <= ovf | add_ovf;
            o_beats   <= cnt_inc;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
         end else if (take) begin
            acc <= sum;
            cnt <= cnt_inc;
            ovf <= ovf | add_ovf;
         end
      end
   end
endmodule

// File: doc/dsp_mac_acc.md
Name: dsp_mac_acc

Overview:
Downstream accumulate/requantise stage that consumes the signed products of dsp_mul.
- Sums a packet of products (one dot product / filter tap window), delimited by a last flag, into a wide accumulator.
- Rounds and shifts the sum back to sample width, saturating, and presents one result per packet.
- Output uses a valid/ready handshake with backpressure to the product stream.

Parameters:
IN_WIDTH, 35, signed product width (2*VALUE_WIDTH+1 of dsp_mul at VALUE_WIDTH=17)
ACC_WIDTH, 48, signed accumulator width; must be >= IN_WIDTH
FRAC_SHIFT, 16, arithmetic right shift applied to the final sum; 0 allowed (no rounding then)
OUT_WIDTH, 17, signed result width
CNT_WIDTH, 16, beat counter width

Ports:
i_clk  in  1  clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  product beat valid
i_data  in  IN_WIDTH  signed product
i_last  in  1  final beat of packet; qualified by i_valid
o_ready  out  1  stage accepts a beat this cycle
o_valid  out  1  result valid
o_data  out  OUT_WIDTH  signed rounded, saturated result
o_sat  out  1  result was clamped at OUT_WIDTH (qualified by o_valid)
o_acc_ovf  out  1  accumulator clamped during this packet (qualified by o_valid)
o_beats  out  CNT_WIDTH  beats in this packet (qualified by o_valid)
i_ready  in  1  downstream accepts result

Behaviour:
- Reset (i_reset=1 at an edge): acc=0, beat count=0, ovf sticky=0, o_valid=0, o_data=0, o_sat=0, o_acc_ovf=0, o_beats=0. Reset mid-packet discards the partial sum; any pending result is dropped.
- Beat accepted iff i_valid && o_ready.
- o_ready = !o_valid || i_ready (combinational). Single result register; no skid buffer.
- Non-last beat: acc <= sat_add(acc, sext(i_data)); count <= count+1 (saturating at all-ones).
- sat_add: on signed ACC_WIDTH overflow, clamp to max/min and set sticky ovf.
- Last beat: sum = sat_add(acc, i_data), including ovf from this add.
- If FRAC_SHIFT>0: r = (sum + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. Rounding is round-half-up toward +inf, computed at ACC_WIDTH+1 bits so the add cannot wrap.
- Clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; o_sat=1 if clamped.
- Registered on the same edge: o_valid=1, o_data, o_sat, o_acc_ovf=sticky|this-add ovf, o_beats=count+1.
- Also on that edge: acc, count and sticky are cleared so the next packet starts clean.
- Latency: result visible on the cycle after the edge that accepted the last beat; one packet per result.
- o_valid && i_ready at an edge with no new last beat: o_valid<=0; outputs hold their values.
- Accepted last beat while the old result is being taken (o_valid && i_ready): the new result replaces it the same edge and o_valid stays 1. Back-to-back packets give full throughput.
- o_valid && !i_ready: o_ready=0 and no beats are accepted. Output holds stable until taken, then upstream resumes.
- i_valid=0 cycles inside a packet: no change (bubbles allowed).
- Single-beat packet (i_last on first beat): result = requantised i_data, o_beats=1.
- No result is emitted without a last beat. i_data/i_last are ignored when i_valid=0.
- FSM (explicit): ACCUM (accepting) / HOLD (o_valid && !i_ready). Transitions follow o_valid/i_ready as above; reset -> ACCUM.

Test Plan:
- Basic sum: beats 196608, 262144(last), i_ready=1 -> one cycle later o_valid=1, o_data=7, o_beats=2, o_sat=0, o_acc_ovf=0.
- Rounding, one packet per beat: 98304(last) -> 2; -98304(last) -> -1; 32767(last) -> 0; 32768(last) -> 1.
- Output saturation: 8589934592(last) -> o_data=65535, o_sat=1; -8589934592(last) -> o_data=-65536, o_sat=1.
- Accumulator overflow (ACC_WIDTH=36, FRAC_SHIFT=0, OUT_WIDTH=36): three beats of 17179869183 -> o_data=34359738367, o_acc_ovf=1.
  - Next packet 5(last) -> o_data=5, o_acc_ovf=0.
- Backpressure and gaps: packet 65536, 65536(last) with i_ready=0 -> o_valid=1, o_data=2, o_ready=0. Hold i_valid with 131072(last) for 5 cycles: output stable, beat not taken. Raise i_ready -> beat accepted the same edge, next o_data=2, o_beats=1, no result lost or duplicated.
- Reset mid-packet: beats 65536, 65536, then i_reset=1 for one cycle -> o_valid=0. Then 65536(last) -> o_data=1, o_beats=1.
